// File: rtl/gpi_matrix.sv
// gpi_matrix: routes synchronized, glitch-filtered accessory inputs onto CTRL_IN lines via a handshake-programmed map
module gpi_matrix #(
   parameter int NUM_IN  = 8,
   parameter int NUM_OUT = 8,
   parameter int SEL_W   = 4,
   parameter int FILT_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_stb,
   input  logic [SEL_W-1:0]   cfg_in_sel,
   input  logic [SEL_W-1:0]   cfg_out_sel,
   input  logic               cfg_en,
   output logic               cfg_ack,
   output logic               cfg_err,
   input  logic [FILT_W-1:0]  filt_len,
   input  logic [NUM_IN-1:0]  line_in,
   input  logic [NUM_OUT-1:0] default_out,
   output logic [NUM_OUT-1:0] line_out
);
   localparam logic [SEL_W:0] in_lim  = (SEL_W+1)'(NUM_IN);
   localparam logic [SEL_W:0] out_lim = (SEL_W+1)'(NUM_OUT);
   logic                stb_s1, stb_s2, stb_s3;
   logic                wr, wr_err;
   logic [NUM_OUT-1:0]  map_vld;
   logic [SEL_W-1:0]    map_idx [NUM_OUT];
   logic [NUM_IN-1:0]   in_s1, y, filt;
   logic [FILT_W-1:0]   cnt [NUM_IN];
   logic [2**SEL_W-1:0] filt_pad;
   assign wr       = stb_s2 & ~stb_s3;
   assign wr_err   = ({1'b0, cfg_out_sel} >= out_lim) | (cfg_en & ({1'b0, cfg_in_sel} >= in_lim));
   // zero-padded so any select index addresses a real bit
   assign filt_pad = (2**SEL_W)'(filt);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stb_s1  <= 1'b0;
         stb_s2  <= 1'b0;
         stb_s3  <= 1'b0;
         cfg_ack <= 1'b0;
         cfg_err <= 1'b0;
         map_vld <= '0;
         for (int j = 0; j < NUM_OUT; j++) map_idx[j] <= '0;
      end else begin
         stb_s1  <= cfg_stb;
         stb_s2  <= stb_s1;
         stb_s3  <= stb_s2;
         cfg_ack <= stb_s3;
         if (wr) begin
            cfg_err <= wr_err;
            for (int j = 0; j < NUM_OUT; j++)
               if (!wr_err && cfg_out_sel == SEL_W'(j)) begin
                  map_vld[j] <= cfg_en;
                  if (cfg_en) map_idx[j] <= cfg_in_sel;
               end
         end
      end
   end
   // a level must persist past filt_len counted cycles before it is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_s1 <= '0;
         y     <= '0;
         filt  <= '0;
         for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
      end else begin
         in_s1 <= line_in;
         y     <= in_s1;
         for (int i = 0; i < NUM_IN; i++)
            if (y[i] == filt[i]) cnt[i] <= '0;
            else if (cnt[i] >= filt_len) begin
               filt[i] <= y[i];
               cnt[i]  <= '0;
            end else cnt[i] <= cnt[i] + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) line_out <= '0;
      else for (int j = 0; j < NUM_OUT; j++)
         line_out[j] <= map_vld[j] ? filt_pad[map_idx[j]] : default_out[j];
   end
endmodule

// File: tb/tb_gpi_matrix.sv
// tb_gpi_matrix: directed checks of mapping, filtering, range errors and handshake timing
module tb_gpi_matrix;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_stb = 1'b0;
   logic [3:0] cfg_in_sel = '0;
   logic [3:0] cfg_out_sel = '0;
   logic       cfg_en = 1'b0;
   logic       cfg_ack, cfg_err;
   logic [3:0] filt_len = '0;
   logic [7:0] line_in = '0;
   logic [7:0] default_out = 8'hA5;
   logic [7:0] line_out;
   int total = 0;
   int bad = 0;
   int n;
   gpi_matrix dut (
      .clk(clk), .rst(rst), .cfg_stb(cfg_stb), .cfg_in_sel(cfg_in_sel),
      .cfg_out_sel(cfg_out_sel), .cfg_en(cfg_en), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
      .filt_len(filt_len), .line_in(line_in), .default_out(default_out), .line_out(line_out)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask
   task automatic wr(input int o, input int i, input logic en, input logic exp_err);
      int c;
      cfg_out_sel = 4'(o);
      cfg_in_sel  = 4'(i);
      cfg_en      = en;
      cfg_stb     = 1'b1;
      c = 0;
      while (!cfg_ack && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("ack_latency", c, 4);
      chk("cfg_err", cfg_err, exp_err);
      cfg_stb = 1'b0;
      c = 0;
      while (cfg_ack && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("ack_fall", cfg_ack, 0);
   endtask
   initial begin
      // reset defaults
      step(3);
      chk("rst_line_out", line_out, 8'h00);
      chk("rst_ack", cfg_ack, 0);
      chk("rst_err", cfg_err, 0);
      rst = 1'b0;
      step(2);
      chk("default_after_rst", line_out, 8'hA5);
      chk("ack_after_rst", cfg_ack, 0);
      chk("err_after_rst", cfg_err, 0);
      // map out3 <- in5, filt_len 0
      default_out = 8'h5A;
      wr(3, 5, 1'b1, 1'b0);
      chk("mapped_low", line_out, 8'h52);
      line_in[5] = 1'b1;
      step(3);
      chk("edge_lat_3", line_out, 8'h52);
      step(1);
      chk("edge_lat_4", line_out, 8'h5A);
      line_in[5] = 1'b0;
      step(4);
      chk("fall_lat_4", line_out, 8'h52);
      default_out = 8'h0F;
      step(1);
      chk("default_lat_1", line_out, 8'h07);
      // glitch filter, filt_len 3
      filt_len = 4'd3;
      default_out = 8'h00;
      line_in[5] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("pulse3_suppressed", line_out, 8'h00);
         if (k == 3) line_in[5] = 1'b0;
      end
      line_in[5] = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         chk($sformatf("pulse4_k%0d", k), line_out, (k >= 7 && k <= 10) ? 8'h08 : 8'h00);
         if (k == 4) line_in[5] = 1'b0;
      end
      filt_len = 4'd0;
      // range errors leave the table alone
      default_out = 8'hFF;
      step(1);
      chk("pre_err_out", line_out, 8'hF7);
      wr(9, 1, 1'b1, 1'b1);
      chk("err_out9_tbl", line_out, 8'hF7);
      wr(3, 12, 1'b1, 1'b1);
      chk("err_in12_tbl", line_out, 8'hF7);
      wr(9, 0, 1'b0, 1'b1);
      chk("err_unmap9_tbl", line_out, 8'hF7);
      wr(3, 5, 1'b1, 1'b0);
      chk("err_cleared_tbl", line_out, 8'hF7);
      // fan-out: out0 and out7 <- in2
      wr(0, 2, 1'b1, 1'b0);
      wr(7, 2, 1'b1, 1'b0);
      chk("fanout_low", line_out, 8'h76);
      line_in[2] = 1'b1;
      step(4);
      chk("fanout_high", line_out, 8'hF7);
      line_in[2] = 1'b0;
      step(4);
      chk("fanout_low2", line_out, 8'h76);
      // unmap out7, check the exact switch cycle
      cfg_out_sel = 4'd7;
      cfg_in_sel  = 4'd0;
      cfg_en      = 1'b0;
      cfg_stb     = 1'b1;
      step(3);
      chk("unmap_old_src", line_out, 8'h76);
      step(1);
      chk("unmap_new_src", line_out, 8'hF6);
      chk("unmap_ack", cfg_ack, 1);
      cfg_stb = 1'b0;
      step(5);
      chk("unmap_ack_fall", cfg_ack, 0);
      // reset in the middle of a handshake
      cfg_out_sel = 4'd4;
      cfg_in_sel  = 4'd2;
      cfg_en      = 1'b1;
      cfg_stb     = 1'b1;
      step(4);
      chk("mid_ack_high", cfg_ack, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ack", cfg_ack, 0);
      chk("mid_rst_out", line_out, 8'h00);
      step(2);
      rst = 1'b0;
      n = 0;
      while (!cfg_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rewrite_ack_lat", n, 4);
      chk("rewrite_err", cfg_err, 0);
      chk("rewrite_table", line_out, 8'hEF);
      cfg_stb = 1'b0;
      step(5);
      chk("final_ack_fall", cfg_ack, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
